// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int unsigned DEF_DATA_W = 256;
   localparam int unsigned DEF_ADDR_W = 32;

   // Watchdog counter width; a zero limit still needs one bit of storage.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit == 0) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way grant: single requester wins, ties go to port 1
// under fixed priority, otherwise to the port that was not granted last.
module rr_arbiter2 import mem_arb_pkg::*; #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       valid,
   output logic       grant
);

   always_comb begin
      valid = |req;
      grant = PORT_I;
      case (req)
         2'b01:   grant = PORT_I;
         2'b10:   grant = PORT_D;
         2'b11:   grant = (FIXED_PRIO != 0) ? PORT_D : ~last_grant;
         default: grant = PORT_I;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache (port 0) and dcache (port 1) line transactions onto one
// memory port; all outputs registered, with a sticky watchdog on BUSY.
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned FIXED_PRIO = 0,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_data_i,
   output logic [DATA_W-1:0] p0_data_o,
   output logic              p0_ack_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_data_i,
   output logic [DATA_W-1:0] p1_data_o,
   output logic              p1_ack_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int unsigned      CNT_W   = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t            state, state_nxt;
   logic              owner, owner_nxt;
   logic              last_grant, last_grant_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              err_nxt, busy_nxt;
   logic              en_nxt, wr_nxt, ack0_nxt, ack1_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt, d0_nxt, d1_nxt;
   logic              arb_valid, arb_grant;

   rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
      .req        ({p1_enable_i, p0_enable_i}),
      .last_grant (last_grant),
      .valid      (arb_valid),
      .grant      (arb_grant)
   );

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      cnt_nxt        = cnt;
      err_nxt        = err_o;
      en_nxt         = mem_enable_o;
      wr_nxt         = mem_write_o;
      addr_nxt       = mem_addr_o;
      wdata_nxt      = mem_data_o;
      d0_nxt         = p0_data_o;
      d1_nxt         = p1_data_o;
      ack0_nxt       = 1'b0;
      ack1_nxt       = 1'b0;
      case (state)
         IDLE: begin
            if (arb_valid) begin
               state_nxt      = BUSY;
               owner_nxt      = arb_grant;
               last_grant_nxt = arb_grant;
               cnt_nxt        = '0;
               en_nxt         = 1'b1;
               if (arb_grant == PORT_D) begin
                  addr_nxt  = p1_addr_i;
                  wdata_nxt = p1_data_i;
                  wr_nxt    = p1_write_i;
               end else begin
                  addr_nxt  = p0_addr_i;
                  wdata_nxt = p0_data_i;
                  wr_nxt    = p0_write_i;
               end
            end
         end
         BUSY: begin
            if (mem_ack_i) begin
               state_nxt = RESP;
               en_nxt    = 1'b0;
               wr_nxt    = 1'b0;
               // Only reads return data; a write leaves the owner's data_o as is.
               if (owner == PORT_D) begin
                  ack1_nxt = 1'b1;
                  if (!mem_write_o) d1_nxt = mem_data_i;
               end else begin
                  ack0_nxt = 1'b1;
                  if (!mem_write_o) d0_nxt = mem_data_i;
               end
            end else begin
               if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
               if ((TIMEOUT != 0) && (cnt_nxt == CNT_MAX)) err_nxt = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         owner        <= PORT_I;
         last_grant   <= PORT_I;
         cnt          <= '0;
         err_o        <= 1'b0;
         busy_o       <= 1'b0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         p0_data_o    <= '0;
         p1_data_o    <= '0;
         p0_ack_o     <= 1'b0;
         p1_ack_o     <= 1'b0;
      end else begin
         state        <= state_nxt;
         owner        <= owner_nxt;
         last_grant   <= last_grant_nxt;
         cnt          <= cnt_nxt;
         err_o        <= err_nxt;
         busy_o       <= busy_nxt;
         mem_enable_o <= en_nxt;
         mem_write_o  <= wr_nxt;
         mem_addr_o   <= addr_nxt;
         mem_data_o   <= wdata_nxt;
         p0_data_o    <= d0_nxt;
         p1_data_o    <= d1_nxt;
         p0_ack_o     <= ack0_nxt;
         p1_ack_o     <= ack1_nxt;
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 256-bit off-chip data-memory port between two cache-line requesters: port 0 is the instruction cache, port 1 is the data cache (dcache_top).
- Sits between the CPU's two cache controllers and the memory model.
- Serializes line reads and writebacks, with round-robin or fixed priority.
- Returns each response only to the port that owns the transaction, and flags a memory that never acknowledges.

Parameters:
- DATA_W, 256, cache-line width in bits.
- ADDR_W, 32, byte-address width.
- FIXED_PRIO, 0, 0 = round-robin on ties; 1 = port 1 (dcache) always wins ties.
- TIMEOUT, 1024, cycles in BUSY before err_o sets; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-low (sampled on clk_i rising edge; 0 = reset)
- p0_enable_i  in  1  icache request; held high until p0_ack_o
- p0_write_i  in  1  icache request is a write
- p0_addr_i  in  ADDR_W  icache line address
- p0_data_i  in  DATA_W  icache write data
- p0_data_o  out  DATA_W  read data returned to icache
- p0_ack_o  out  1  one-cycle completion pulse to icache
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same set for dcache
- mem_data_i  in  DATA_W  memory read data
- mem_ack_i  in  1  memory completion pulse
- mem_data_o  out  DATA_W  memory write data
- mem_addr_o  out  ADDR_W  memory address
- mem_enable_o  out  1  memory request; held until mem_ack_i
- mem_write_o  out  1  memory write strobe
- busy_o  out  1  high when state is not IDLE
- err_o  out  1  sticky watchdog error

Behaviour:
- Reset values (rst_i=0 at an edge):
  - state=IDLE; all outputs 0; last_grant=0; timeout counter=0; err_o=0.
  - Reset mid-transaction abandons it: no ack is issued, and a later mem_ack_i is ignored.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If any pN_enable_i is high, choose the owner, latch its addr/data/write into mem_addr_o/mem_data_o/mem_write_o, set mem_enable_o=1 and owner=N, then go to BUSY.
  - Latency from request edge to mem_enable_o is 1 cycle.
- Arbitration:
  - Single requester wins.
  - Both high, FIXED_PRIO=1: port 1 wins.
  - Both high, FIXED_PRIO=0: the port not equal to last_grant wins.
  - last_grant updates to the owner at each grant.
- BUSY:
  - mem_* outputs are held stable; requester input changes are ignored.
  - When mem_ack_i=1: capture mem_data_i into the owner's pN_data_o (reads only; writes leave data_o unchanged), pulse owner pN_ack_o=1, drop mem_enable_o and mem_write_o, go to RESP.
  - The non-owner's ack and data_o are untouched.
- RESP:
  - Lasts one cycle. The ack pulse is visible in it; requester enables are ignored during it.
  - Next state is IDLE. A still-pending other port is granted on the IDLE cycle that follows.
  - Minimum cycles between successive grants: 3.
- mem_ack_i outside BUSY is ignored.
- Watchdog:
  - Counter clears on entering BUSY and increments each BUSY cycle without mem_ack_i. Width is clog2(TIMEOUT+1); it saturates, never wraps.
  - On reaching TIMEOUT, err_o=1 (sticky until reset). The FSM keeps waiting in BUSY.
- A port deasserting enable before its ack is a protocol violation. The transaction still completes and ack is still pulsed.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, BUSY, RESP), port-index constants PORT_I=0 and PORT_D=1, default DATA_W/ADDR_W.
- One natural sub-module, rr_arbiter2: combinational 2-way grant from the two requests, last_grant and FIXED_PRIO.
- Watchdog counter and FSM stay inline.

Test Plan:
- Single read: p1 read at addr 0x0000_0400; memory acks 10 cycles after mem_enable_o with data 0xA5..A5.
  - Required: mem_addr_o=0x400, mem_write_o=0.
  - Required: p1_ack_o pulses once with p1_data_o=0xA5..A5; p0_ack_o stays 0.
- Simultaneous requests, FIXED_PRIO=0 from reset (p0 read 0x100, p1 write 0x200):
  - Required grant order: p1 first (mem_write_o=1, addr 0x200), then p0 (addr 0x100) starting 3 cycles after p1's grant.
  - Repeat the tie: p1 granted first again, since last_grant=0 after p0.
- Fixed priority, FIXED_PRIO=1: both ports request continuously for 4 transactions.
  - Required: every tie goes to p1; p0 is served only after p1's enable drops.
- Watchdog, TIMEOUT=16: memory never acks.
  - Required: err_o rises exactly 16 BUSY cycles after mem_enable_o rises and stays 1.
  - A late mem_ack_i at cycle 20 still completes the transaction; err_o remains 1.
- Reset mid-BUSY: rst_i=0 for 1 cycle while waiting; mem_ack_i arrives 2 cycles later.
  - Required: all outputs 0 and state IDLE after reset; no pN_ack_o pulse.
- Stray ack: mem_ack_i pulsed while IDLE with no requests.
  - Required: no ack on either port, no data_o change, busy_o=0.
